// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe_reg
// Description : Elastic inter-stage pipeline register. It carries a control
//               bundle and a payload bundle through STAGES slots. Every slot
//               has a main entry and a skid entry, so each slot holds up to
//               two entries. Valid/ready handshaking lets back-pressure stall
//               upstream without bubbles, and ready is always a register
//               output. Flush turns the whole pipe into bubbles in a single
//               cycle. An occupancy count is provided for hazard logic.
//
// Parameters  : CTRL_WIDTH - control bundle width (cleared in a bubble)
//               DATA_WIDTH - payload bundle width
//               STAGES     - number of register slots, legal range 1..8
//               CNT_WIDTH  - occupancy counter width
//
// Ports       : clk        - clock, rising edge
//               rst        - synchronous reset, active high
//               flush_in   - synchronous flush, discards all held entries
//               in_valid   - upstream entry present
//               in_ready   - block accepts this cycle (registered)
//               in_ctrl    - control bundle in
//               in_data    - payload bundle in
//               out_valid  - entry present at output
//               out_ready  - downstream accepts
//               out_ctrl   - control bundle out, zero when out_valid=0
//               out_data   - payload bundle out, zero when out_valid=0
//               occupancy  - entries currently held, 0..2*STAGES
//
// Revision    : 1.0 - initial elastic implementation
// ============================================================================
module elastic_pipe_reg #(
    parameter int CTRL_WIDTH = 8,
    parameter int DATA_WIDTH = 96,
    parameter int STAGES     = 1,
    parameter int CNT_WIDTH  = $clog2(2*STAGES+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  occupancy
);

    localparam int                   c_last_slot = STAGES - 1;
    localparam logic [CNT_WIDTH-1:0] c_max_occ   = CNT_WIDTH'(2*STAGES);

    // ------------------------------------------------------------------
    // Slot state
    // ------------------------------------------------------------------
    logic [STAGES-1:0]     r_main_v;
    logic [STAGES-1:0]     r_skid_v;
    logic [CTRL_WIDTH-1:0] r_main_ctrl [STAGES];
    logic [DATA_WIDTH-1:0] r_main_data [STAGES];
    logic [CTRL_WIDTH-1:0] r_skid_ctrl [STAGES];
    logic [DATA_WIDTH-1:0] r_skid_data [STAGES];
    logic [CNT_WIDTH-1:0]  r_occ;

    // ------------------------------------------------------------------
    // Inter-slot links
    // ------------------------------------------------------------------
    logic [STAGES-1:0]     w_up_valid;   // entry offered to slot k
    logic [STAGES-1:0]     w_dn_ready;   // downstream of slot k accepts
    logic [STAGES-1:0]     w_take;       // slot k hands its main entry on
    logic [STAGES-1:0]     w_accept;     // slot k takes the offered entry
    logic [CTRL_WIDTH-1:0] w_up_ctrl [STAGES];
    logic [DATA_WIDTH-1:0] w_up_data [STAGES];
    logic                  w_in_xfer;
    logic                  w_out_xfer;

    always_comb begin
        w_up_valid = '0;
        w_dn_ready = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_up_ctrl[k] = '0;
            w_up_data[k] = '0;
        end

        // Slot 0 is fed from the block input, every other slot from the
        // main entry of the slot before it.
        w_up_valid[0] = in_valid;
        w_up_ctrl[0]  = in_ctrl;
        w_up_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            w_up_valid[k] = r_main_v[k-1];
            w_up_ctrl[k]  = r_main_ctrl[k-1];
            w_up_data[k]  = r_main_data[k-1];
        end

        // Ready toward upstream is only the registered skid state, which
        // keeps out_ready from ever reaching in_ready combinationally.
        w_dn_ready[c_last_slot] = out_ready;
        for (int k = 0; k < STAGES - 1; k++) begin
            w_dn_ready[k] = !r_skid_v[k+1];
        end

        w_take     = r_main_v & w_dn_ready;
        w_accept   = w_up_valid & ~r_skid_v;
        w_in_xfer  = in_valid & !r_skid_v[0];
        w_out_xfer = r_main_v[c_last_slot] & out_ready;
    end

    // ------------------------------------------------------------------
    // Slot update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            r_main_v <= '0;
            r_skid_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_main_ctrl[k] <= '0;
                r_main_data[k] <= '0;
                r_skid_ctrl[k] <= '0;
                r_skid_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_take[k]) begin
                    if (r_skid_v[k]) begin
                        // Skid refills main; ready is low so nothing new
                        // can arrive in this cycle.
                        r_main_ctrl[k] <= r_skid_ctrl[k];
                        r_main_data[k] <= r_skid_data[k];
                        r_skid_v[k]    <= 1'b0;
                    end else if (w_accept[k]) begin
                        r_main_ctrl[k] <= w_up_ctrl[k];
                        r_main_data[k] <= w_up_data[k];
                    end else begin
                        r_main_v[k]    <= 1'b0;
                    end
                end else if (w_accept[k]) begin
                    if (!r_main_v[k]) begin
                        r_main_v[k]    <= 1'b1;
                        r_main_ctrl[k] <= w_up_ctrl[k];
                        r_main_data[k] <= w_up_data[k];
                    end else begin
                        // Main is stalled: park the entry in the skid so the
                        // upstream transfer already committed is not lost.
                        r_skid_v[k]    <= 1'b1;
                        r_skid_ctrl[k] <= w_up_ctrl[k];
                        r_skid_data[k] <= w_up_data[k];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            r_occ <= '0;
        end else begin
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // The counter must never pass 2*STAGES or go below zero, and it must
    // always agree with the number of valid entries actually held.
    always_ff @(posedge clk) begin
        if (!rst && !flush_in) begin
            assert (!(w_in_xfer && !w_out_xfer && (r_occ == c_max_occ)));
            assert (!(w_out_xfer && !w_in_xfer && (r_occ == '0)));
            assert (r_occ == CNT_WIDTH'($countones({r_main_v, r_skid_v})));
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = !r_skid_v[0];
    assign out_valid = r_main_v[c_last_slot];
    // A bubble must present all-zero control so no write enable leaks out.
    assign out_ctrl  = r_main_ctrl[c_last_slot] & {CTRL_WIDTH{out_valid}};
    assign out_data  = r_main_data[c_last_slot] & {DATA_WIDTH{out_valid}};
    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_elastic_pipe_reg
// Description : Self-checking bench for elastic_pipe_reg. Three instances
//               (STAGES = 1, 2, 3) are exercised one at a time against a
//               FIFO scoreboard that also records the acceptance cycle of
//               every entry.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_elastic_pipe_reg;

    localparam int CW = 8;
    localparam int DW = 96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    rst;
    logic [2:0]    flush;
    logic [2:0]    in_valid;
    logic [2:0]    in_ready;
    logic [2:0]    out_valid;
    logic [2:0]    out_ready;
    logic [CW-1:0] in_ctrl  [3];
    logic [DW-1:0] in_data  [3];
    logic [CW-1:0] out_ctrl [3];
    logic [DW-1:0] out_data [3];
    logic [1:0]    occ1;
    logic [2:0]    occ2;
    logic [2:0]    occ3;

    elastic_pipe_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst[0]), .flush_in(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_ctrl(out_ctrl[0]), .out_data(out_data[0]), .occupancy(occ1)
    );

    elastic_pipe_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst[1]), .flush_in(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_ctrl(out_ctrl[1]), .out_data(out_data[1]), .occupancy(occ2)
    );

    elastic_pipe_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .STAGES(3)) u_s3 (
        .clk(clk), .rst(rst[2]), .flush_in(flush[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_ctrl(in_ctrl[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_ctrl(out_ctrl[2]), .out_data(out_data[2]), .occupancy(occ3)
    );

    typedef struct packed {
        int            stamp;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct packed {
        logic          ov;
        logic [CW-1:0] oc;
        logic [DW-1:0] od;
        int            occ;
        logic          ir;
        logic          inx;
        logic          outx;
        int            depth;
        logic          have_head;
        ent_t          head;
        int            lat;
    } obs_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    function automatic int occ_of(input int i);
        case (i)
            0:       return int'(occ1);
            1:       return int'(occ2);
            default: return int'(occ3);
        endcase
    endfunction

    function automatic logic [DW-1:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // One clock cycle on instance i: drive, observe before the edge, then
    // advance the scoreboard by the transfers that happened at the edge.
    task automatic cyc(input int i, input logic v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic rs, output obs_t o);
        ent_t e;
        in_valid[i]  = v;
        in_ctrl[i]   = c;
        in_data[i]   = d;
        out_ready[i] = ordy;
        flush[i]     = fl;
        rst[i]       = rs;
        #1;
        o           = '0;
        o.ov        = out_valid[i];
        o.oc        = out_ctrl[i];
        o.od        = out_data[i];
        o.occ       = occ_of(i);
        o.ir        = in_ready[i];
        o.inx       = v && in_ready[i];
        o.outx      = out_valid[i] && ordy;
        o.depth     = sb.size();
        o.have_head = (sb.size() > 0);
        o.lat       = -1;
        if (sb.size() > 0) begin
            o.head = sb[0];
            o.lat  = cyc_n - sb[0].stamp;
        end
        @(posedge clk);
        if (fl || rs) begin
            sb.delete();
        end else begin
            if (o.outx && sb.size() > 0) void'(sb.pop_front());
            if (o.inx) begin
                e.stamp = cyc_n;
                e.ctrl  = c;
                e.data  = d;
                sb.push_back(e);
            end
        end
        cyc_n++;
        #1;
        in_valid[i] = 1'b0;
        flush[i]    = 1'b0;
        rst[i]      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        rst = 3'b000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready[i]);
            end
            checks++;
            if (out_valid[i] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid[i]);
            end
            checks++;
            if (out_ctrl[i] !== '0 || out_data[i] !== '0) begin
                errors++; $display("FAIL reset_out_bundles[%0d]: got %h/%h want 0", i, out_ctrl[i], out_data[i]);
            end
            checks++;
            if (occ_of(i) != 0) begin
                errors++; $display("FAIL reset_occupancy[%0d]: got %0d want 0", i, occ_of(i));
            end
        end
        sb.delete();
    endtask

    task automatic test_stream_s1();
        obs_t o;
        int   n_in  = 0;
        int   n_out = 0;
        int   iters = 0;
        for (int t = 0; t < 40 && n_out < 16; t++) begin
            cyc(0, n_in < 16, CW'(n_in + 1), rnd96(), 1'b1, 1'b0, 1'b0, o);
            iters++;
            if (o.inx) n_in++;
            checks++;
            if (o.ir !== 1'b1) begin
                errors++; $display("FAIL s1_in_ready t=%0d: got %b want 1", t, o.ir);
            end
            checks++;
            if (t > 0 && o.occ != 1) begin
                errors++; $display("FAIL s1_occupancy t=%0d: got %0d want 1", t, o.occ);
            end
            if (o.outx) begin
                n_out++;
                checks++;
                if (o.oc !== CW'(n_out) || !o.have_head || o.od !== o.head.data) begin
                    errors++; $display("FAIL s1_order: got %h/%h want %h/%h", o.oc, o.od, CW'(n_out), o.head.data);
                end
                checks++;
                if (o.lat != 1) begin
                    errors++; $display("FAIL s1_latency: got %0d want 1", o.lat);
                end
            end
        end
        checks++;
        if (n_out != 16 || iters != 17) begin
            errors++; $display("FAIL s1_throughput: got %0d outs in %0d cycles want 16 in 17", n_out, iters);
        end
    endtask

    task automatic test_backpressure_s3();
        obs_t o;
        int   acc     = 0;
        int   sixth   = -1;
        int   n_out   = 0;
        logic started = 1'b0;
        for (int t = 0; t < 20; t++) begin
            cyc(2, acc < 8, CW'(acc + 1), rnd96(), 1'b0, 1'b0, 1'b0, o);
            if (o.inx) begin
                acc++;
                if (acc == 6) sixth = t;
            end
            if (sixth >= 0 && t > sixth) begin
                checks++;
                if (o.ir !== 1'b0) begin
                    errors++; $display("FAIL s3_stall_ready t=%0d: got %b want 0", t, o.ir);
                end
            end
            checks++;
            if (o.occ != o.depth) begin
                errors++; $display("FAIL s3_fill_occ t=%0d: got %0d want %0d", t, o.occ, o.depth);
            end
        end
        checks++;
        if (acc != 6 || occ_of(2) != 6 || in_ready[2] !== 1'b0) begin
            errors++; $display("FAIL s3_absorb: got acc=%0d occ=%0d rdy=%b want 6/6/0", acc, occ_of(2), in_ready[2]);
        end
        for (int t = 0; t < 30 && n_out < 8; t++) begin
            cyc(2, acc < 8, CW'(acc + 1), rnd96(), 1'b1, 1'b0, 1'b0, o);
            if (o.inx) acc++;
            checks++;
            if ((started || t == 0) && !o.ov) begin
                errors++; $display("FAIL s3_gap t=%0d: got out_valid=0 want 1", t);
            end
            if (o.outx) begin
                started = 1'b1;
                n_out++;
                checks++;
                if (o.oc !== CW'(n_out) || !o.have_head || o.od !== o.head.data) begin
                    errors++; $display("FAIL s3_order: got %h want %h", o.oc, CW'(n_out));
                end
            end
        end
        checks++;
        if (n_out != 8 || acc != 8) begin
            errors++; $display("FAIL s3_release: got outs=%0d accepts=%0d want 8/8", n_out, acc);
        end
    endtask

    task automatic test_random_s2();
        obs_t o;
        logic v;
        logic ordy;
        for (int t = 0; t < 10000; t++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ((t / 1000) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc(1, v, CW'($urandom), rnd96(), ordy, 1'b0, 1'b0, o);
            checks++;
            if (o.occ != o.depth) begin
                errors++; $display("FAIL rnd_occ t=%0d: got %0d want %0d", t, o.occ, o.depth);
            end
            checks++;
            if (o.ov) begin
                if (!o.have_head || o.oc !== o.head.ctrl || o.od !== o.head.data) begin
                    errors++; $display("FAIL rnd_data t=%0d: got %h/%h want %h/%h", t, o.oc, o.od, o.head.ctrl, o.head.data);
                end
            end else if (o.oc !== '0 || o.od !== '0) begin
                errors++; $display("FAIL rnd_bubble t=%0d: got %h/%h want 0", t, o.oc, o.od);
            end
            if (o.outx) begin
                checks++;
                if (o.lat < 2) begin
                    errors++; $display("FAIL rnd_latency t=%0d: got %0d want >=2", t, o.lat);
                end
            end
        end
        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            cyc(1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, o);
            if (o.ov && (!o.have_head || o.oc !== o.head.ctrl || o.od !== o.head.data)) begin
                checks++; errors++; $display("FAIL rnd_drain: got %h want %h", o.oc, o.head.ctrl);
            end
        end
        checks++;
        if (sb.size() != 0 || occ_of(1) != 0) begin
            errors++; $display("FAIL rnd_loss: got %0d undelivered occ=%0d want 0/0", sb.size(), occ_of(1));
        end
    endtask

    task automatic test_flush_s2();
        obs_t o;
        for (int t = 0; t < 20 && occ_of(1) < 4; t++) begin
            cyc(1, 1'b1, CW'($urandom), rnd96(), 1'b0, 1'b0, 1'b0, o);
        end
        checks++;
        if (occ_of(1) != 4) begin
            errors++; $display("FAIL flush_fill: got occ=%0d want 4", occ_of(1));
        end
        for (int sc = 0; sc < 2; sc++) begin
            cyc(1, 1'b1, 8'hAD, 96'hDEAD, 1'b0, 1'b1, 1'b0, o);
            checks++;
            if (out_valid[1] !== 1'b0 || out_ctrl[1] !== '0 || out_data[1] !== '0) begin
                errors++; $display("FAIL flush_out[%0d]: got %b %h/%h want 0", sc, out_valid[1], out_ctrl[1], out_data[1]);
            end
            checks++;
            if (occ_of(1) != 0 || in_ready[1] !== 1'b1) begin
                errors++; $display("FAIL flush_state[%0d]: got occ=%0d rdy=%b want 0/1", sc, occ_of(1), in_ready[1]);
            end
            for (int t = 0; t < 6; t++) begin
                cyc(1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, o);
                checks++;
                if (o.ov !== 1'b0) begin
                    errors++; $display("FAIL flush_leak[%0d]: got %h/%h want no output", sc, o.oc, o.od);
                end
            end
            // Second pass flushes with a single entry held and in_ready high.
            cyc(1, 1'b1, 8'h11, rnd96(), 1'b0, 1'b0, 1'b0, o);
        end
    endtask

    task automatic test_reset_mid_s2();
        obs_t o;
        logic found = 1'b0;
        for (int t = 0; t < 20 && occ_of(1) < 3; t++) begin
            cyc(1, 1'b1, CW'($urandom), rnd96(), 1'b0, 1'b0, 1'b0, o);
        end
        checks++;
        if (occ_of(1) != 3) begin
            errors++; $display("FAIL rstmid_fill: got occ=%0d want 3", occ_of(1));
        end
        cyc(1, 1'b1, 8'h5A, rnd96(), 1'b1, 1'b0, 1'b1, o);
        checks++;
        if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || out_ctrl[1] !== '0 ||
            out_data[1] !== '0 || occ_of(1) != 0) begin
            errors++; $display("FAIL rstmid_state: got rdy=%b ov=%b ctrl=%h occ=%0d want 1/0/0/0",
                               in_ready[1], out_valid[1], out_ctrl[1], occ_of(1));
        end
        cyc(1, 1'b1, 8'h77, rnd96(), 1'b1, 1'b0, 1'b0, o);
        for (int t = 0; t < 8 && !found; t++) begin
            cyc(1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, o);
            if (o.outx) begin
                found = 1'b1;
                checks++;
                if (o.oc !== 8'h77 || o.lat != 2) begin
                    errors++; $display("FAIL rstmid_new: got ctrl=%h lat=%0d want 77/2", o.oc, o.lat);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rstmid_timeout: got no output want ctrl 77");
        end
    endtask

    task automatic test_simul_s2();
        obs_t o;
        int   n_out = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1'b1, CW'(8'hC1 + k), rnd96(), 1'b0, 1'b0, 1'b0, o);
        end
        checks++;
        if (occ_of(1) != 3 || in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL simul_fill: got occ=%0d rdy=%b want 3/1", occ_of(1), in_ready[1]);
        end
        cyc(1, 1'b1, 8'hC4, rnd96(), 1'b1, 1'b0, 1'b0, o);
        checks++;
        if (!(o.inx && o.outx) || o.oc !== 8'hC1) begin
            errors++; $display("FAIL simul_xfer: got in=%b out=%b ctrl=%h want 1/1/c1", o.inx, o.outx, o.oc);
        end
        checks++;
        if (occ_of(1) != 3) begin
            errors++; $display("FAIL simul_occ: got %0d want 3", occ_of(1));
        end
        for (int t = 0; t < 12 && n_out < 3; t++) begin
            cyc(1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, o);
            if (o.outx) begin
                n_out++;
                checks++;
                if (o.oc !== CW'(8'hC1 + n_out) || !o.have_head || o.od !== o.head.data) begin
                    errors++; $display("FAIL simul_order: got %h want %h", o.oc, CW'(8'hC1 + n_out));
                end
            end
        end
        checks++;
        if (n_out != 3 || occ_of(1) != 0) begin
            errors++; $display("FAIL simul_drain: got outs=%0d occ=%0d want 3/0", n_out, occ_of(1));
        end
    endtask

    initial begin
        rst       = 3'b111;
        flush     = 3'b000;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            in_ctrl[i] = '0;
            in_data[i] = '0;
        end
        test_reset();
        test_stream_s1();
        test_backpressure_s3();
        test_random_s2();
        test_flush_s2();
        test_reset_mid_s2();
        test_simul_s2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
